// File: rtl/adc_sequencer_if.sv
// rtl/adc_sequencer_if.sv - result stream between the sequencer and its consumer
interface adc_sequencer_if #(
   parameter int Madc = 17
);
   logic [Madc-1:0] result;
   logic            result_valid;
   logic            result_ready;

   modport master (
      output result,
      output result_valid,
      input  result_ready
   );

   modport slave (
      input  result,
      input  result_valid,
      output result_ready
   );
endinterface

// File: rtl/adc_sequencer.sv
// rtl/adc_sequencer.sv - SAR ADC conversion sequencer
// Walks init/sample/compare/update and collects comparator decisions MSB-first.
module adc_sequencer #(
   parameter int Madc  = 17,
   parameter int SampW = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [SampW-1:0]        samp_cycles,
   input  logic                    comp_out,
   output logic                    seq_init,
   output logic                    seq_samp,
   output logic                    seq_comp,
   output logic                    seq_update,
   output logic                    busy,
   adc_sequencer_if.master         res_if
);

   localparam int KW = $clog2(Madc);
   localparam logic [KW-1:0] KLAST = KW'(Madc - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SAMP,
      S_COMP,
      S_UPD,
      S_HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [SampW-1:0] samp_q, samp_d;
   logic [Madc-1:0]  sh_q, sh_d;
   logic [Madc-1:0]  result_q, result_d;
   logic             valid_q, valid_d;
   logic             init_q, init_d;
   logic             smp_q, smp_d;
   logic             cmp_q, cmp_d;
   logic             upd_q, upd_d;
   logic             busy_q, busy_d;

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      samp_d   = samp_q;
      sh_d     = sh_q;
      result_d = result_q;
      valid_d  = valid_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // samp_q holds remaining cycles minus one; zero behaves as one
               samp_d  = (samp_cycles == '0) ? '0 : samp_cycles - SampW'(1);
               k_d     = '0;
               state_d = S_INIT;
            end
         end
         S_INIT: state_d = S_SAMP;
         S_SAMP: begin
            if (samp_q == '0) begin
               state_d = S_COMP;
            end else begin
               samp_d = samp_q - SampW'(1);
            end
         end
         S_COMP: state_d = S_UPD;
         S_UPD: begin
            sh_d = {sh_q[Madc-2:0], comp_out};
            if (k_q != KLAST) begin
               k_d     = k_q + KW'(1);
               state_d = S_COMP;
            end else begin
               result_d = {sh_q[Madc-2:0], comp_out};
               valid_d  = 1'b1;
               state_d  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (valid_q && res_if.result_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it
      init_d = (state_d == S_INIT);
      smp_d  = (state_d == S_SAMP);
      cmp_d  = (state_d == S_COMP);
      upd_d  = (state_d == S_UPD) && (k_d != KLAST);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         k_q      <= '0;
         samp_q   <= '0;
         sh_q     <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         init_q   <= 1'b0;
         smp_q    <= 1'b0;
         cmp_q    <= 1'b0;
         upd_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         samp_q   <= samp_d;
         sh_q     <= sh_d;
         result_q <= result_d;
         valid_q  <= valid_d;
         init_q   <= init_d;
         smp_q    <= smp_d;
         cmp_q    <= cmp_d;
         upd_q    <= upd_d;
         busy_q   <= busy_d;
      end
   end

   assign seq_init            = init_q;
   assign seq_samp            = smp_q;
   assign seq_comp            = cmp_q;
   assign seq_update          = upd_q;
   assign busy                = busy_q;
   assign res_if.result       = result_q;
   assign res_if.result_valid = valid_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// tb/tb_adc_sequencer.sv - directed bench for adc_sequencer
module tb_adc_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] samp_cycles;
   logic       comp_out;
   logic       seq_init, seq_samp, seq_comp, seq_update, busy;
   int         total = 0;
   int         bad   = 0;

   adc_sequencer_if #(.Madc(17)) res_if ();

   adc_sequencer #(.Madc(17), .SampW(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .samp_cycles (samp_cycles),
      .comp_out    (comp_out),
      .seq_init    (seq_init),
      .seq_samp    (seq_samp),
      .seq_comp    (seq_comp),
      .seq_update  (seq_update),
      .busy        (busy),
      .res_if      (res_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One conversion; cycle c counts from t0 (edge that samples start) at negedges
   task automatic run(input logic [7:0] samp, input logic [16:0] pat,
                      input bit hold_start, input int bp_cycles);
      int c, ns, nc, nu, ni, vc, s_eff, idx;
      s_eff = (samp == 0) ? 1 : int'(samp);
      c = 0; ns = 0; nc = 0; nu = 0; ni = 0; vc = 0;
      samp_cycles  = samp;
      res_if.result_ready = (bp_cycles == 0);
      @(negedge clk);
      start    = 1'b1;
      comp_out = 1'b0;
      while (vc == 0 && c < 300) begin
         @(negedge clk);
         c++;
         if (c == 1) start = 1'b0;
         if (hold_start && c == s_eff + 3) start = 1'b1;
         check("onehot", 32'($countones({seq_init, seq_samp, seq_comp, seq_update}) <= 1), 32'd1);
         if (c == 1) check("init_t1", 32'(seq_init), 32'd1);
         if (seq_init) ni++;
         if (seq_samp) ns++;
         if (seq_update) nu++;
         if (seq_comp) begin
            nc++;
            idx = 17 - nc;
            if (idx >= 0) comp_out = pat[idx];
         end
         if (res_if.result_valid) vc = c;
      end
      if (vc == 0) begin
         check("valid_timeout", 32'd0, 32'd1);
         return;
      end
      check("latency", 32'(vc), 32'(2 + s_eff + 2 * 17));
      check("n_init", 32'(ni), 32'd1);
      check("n_samp", 32'(ns), 32'(s_eff));
      check("n_comp", 32'(nc), 32'd17);
      check("n_upd", 32'(nu), 32'd16);
      check("result", 32'(res_if.result), 32'(pat));
      check("busy_hold", 32'(busy), 32'd1);
      for (int i = 0; i < bp_cycles; i++) begin
         @(negedge clk);
         start = i[0];
         check("bp_result", 32'(res_if.result), 32'(pat));
         check("bp_valid", 32'(res_if.result_valid), 32'd1);
         check("bp_busy", 32'(busy), 32'd1);
         check("bp_noinit", 32'(seq_init), 32'd0);
      end
      if (bp_cycles > 0) begin
         start = 1'b0;
         res_if.result_ready = 1'b1;
      end
      @(negedge clk);
      check("valid_drop", 32'(res_if.result_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("result_kept", 32'(res_if.result), 32'(pat));
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      comp_out = 1'b0;
      samp_cycles = 8'd4;
      res_if.result_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_seq", 32'({seq_init, seq_samp, seq_comp, seq_update}), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(res_if.result_valid), 32'd0);
      check("rst_result", 32'(res_if.result), 32'd0);
      rst = 1'b0;

      run(8'd4, 17'h16AAA, 1'b0, 0);
      run(8'd0, 17'h1FFFF, 1'b0, 0);
      run(8'd3, 17'h00000, 1'b0, 10);
      run(8'd2, 17'h0A5C3, 1'b1, 0);

      // start still high: a fresh conversion begins only after IDLE
      @(negedge clk);
      check("rearm_init", 32'(seq_init), 32'd1);
      start = 1'b0;
      samp_cycles = 8'd6;
      @(negedge clk);
      check("rearm_samp", 32'(seq_samp), 32'd1);

      rst = 1'b1;
      @(negedge clk);
      check("abort_seq", 32'({seq_init, seq_samp, seq_comp, seq_update}), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(res_if.result_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      run(8'd5, 17'h13579, 1'b0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc_sequencer.md
Name: adc_sequencer

Overview:
- Single-clock controller that drives the SAR ADC core's sequencing inputs through one full conversion: init, sample, then Madc compare/update cycles.
- Collects the serial comparator decisions (comp_out) MSB-first into a Madc-bit code.
- Presents the code downstream with a valid/ready handshake.
- Sits directly upstream of the adc core (drives seq_*) and directly downstream of it (consumes comp_out).

Parameters:
- Madc, 17, comparison cycles per conversion; equals the adc core's Madc; result width.
- SampW, 8, width of the samp_cycles input.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request, sampled only in IDLE.
- samp_cycles  input  SampW  sampling window length in cycles; latched at start; 0 treated as 1.
- comp_out  input  1  comparator decision from the adc core.
- seq_init  output  1  init pulse to adc core.
- seq_samp  output  1  sampling window to adc core.
- seq_comp  output  1  comparator strobe to adc core.
- seq_update  output  1  SAR logic update strobe to adc core.
- busy  output  1  high in every state except IDLE.
- result  output  Madc  conversion code, MSB = first decision.
- result_valid  output  1  result holds a code not yet accepted.
- result_ready  input  1  downstream accept.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
  - On rst: state=IDLE; all seq_* = 0; busy=0; result_valid=0; result=0; bit counter=0; shift register=0.
  - rst mid-conversion aborts immediately, discards partial bits and takes priority over all other inputs.
- Output timing: all outputs are registered, Moore-style, with no combinational path from inputs to outputs.
- States: IDLE, INIT, SAMP, COMP, UPD, HOLD.
- IDLE: outputs low. If start=1, latch S = max(samp_cycles,1), clear counter k=0, go to INIT.
- INIT: exactly 1 cycle; seq_init=1; go to SAMP.
- SAMP: exactly S cycles; seq_samp=1 throughout; then go to COMP.
- COMP: exactly 1 cycle; seq_comp=1; go to UPD.
- UPD:
  - Lasts exactly 1 cycle.
  - At the closing edge, shift comp_out in: sh <= {sh[Madc-2:0], comp_out}.
  - seq_update=1 only when k < Madc-1. The final decision drives no DAC update.
  - If k < Madc-1: k <= k+1 and go to COMP.
  - Otherwise: result <= the completed shift value, result_valid <= 1, go to HOLD.
- HOLD:
  - busy=1; wait for result_ready.
  - When result_valid and result_ready are both high, result_valid <= 0 and go to IDLE next cycle.
  - result stays stable while result_valid=1.
  - result holds its last value after acceptance.
- Timing from start sampled high at edge t0:
  - seq_init is high in cycle t0+1.
  - seq_samp is high in cycles t0+2 .. t0+1+S.
  - The comp/upd pairs follow.
  - result_valid rises at cycle t0+2+S+2*Madc.
  - With result_ready held high, the earliest next start is accepted 2 cycles after result_valid rises.
- start is ignored in every state except IDLE. No queuing.
- The bit counter width is clog2(Madc) and never wraps, since it exits at Madc-1.
- Invariant: seq_init, seq_samp, seq_comp and seq_update are mutually exclusive (one-hot or all zero) every cycle.

Test Plan:
- Reset defaults: assert rst 3 cycles mid-SAMP -> next cycle all seq_*=0, busy=0, result_valid=0; a new start then runs a complete, clean conversion.
- Basic conversion: Madc=17, samp_cycles=4, start pulse at t0, comp_out pattern 1,0,1,1,0... (alternating after the third bit) -> seq_samp high for exactly 4 cycles; 17 seq_comp pulses; 16 seq_update pulses; result_valid at t0+40; result bits match the pattern MSB-first; result_ready=1 -> IDLE.
- samp_cycles=0 -> seq_samp high for exactly 1 cycle; total latency to result_valid = t0+37 for Madc=17.
- Backpressure: hold result_ready=0 for 10 cycles after valid -> result stable, busy=1, start pulses ignored; then ready=1 -> valid drops next cycle.
- start asserted during COMP/UPD and held high through the whole conversion -> only one conversion runs until IDLE; the next conversion begins only after IDLE is re-entered.
- All-ones and all-zeros comp_out -> result=17'h1FFFF and 17'h00000 respectively; the one-hot invariant on seq_* is checked by assertion every cycle.
